// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame size, default bit
// timing and the receiver FSM state encoding.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 87;  // 10 MHz clk / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. rdata always shows the head entry; when
// the FIFO is empty it keeps showing the most recent head value instead
// of a stale memory slot. A pop frees a slot in the same cycle, so a push
// into a full FIFO is accepted if it coincides with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign rdata   = empty ? last_q : mem[rd_ptr];

  // Storage write; pointers define validity so the array needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); occupancy tracks both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Remember the head while non-empty so rdata holds it once drained.
  always_ff @(posedge clk) begin
    if (!rst_n)      last_q <= '0;
    else if (!empty) last_q <= mem[rd_ptr];
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. rx_i is synchronized, the start bit is confirmed at
// its midpoint, data and stop bits are sampled one bit period apart from
// there, and good bytes are pushed into a small FIFO exposed as a
// valid/ready stream.
// Stream handshake: rx_valid_o means a byte is at the FIFO head; the byte
// transfers on a rising edge where rx_valid_o && rx_ready_i; rx_data_o is
// stable while rx_valid_o is high and not yet accepted.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_e            state;
  logic                 sync1;
  logic                 sync2;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 stop_good;

  // Two-flop synchronizer; reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_i;
      sync2 <= sync1;
    end
  end

  // A valid stop bit is seen on the last count of the STOP bit period.
  assign stop_good = (state == STOP) && (clk_cnt == CNT_LAST) && sync2;
  // Full flag is the pre-edge value; a simultaneous pop makes room.
  assign fifo_push = stop_good && (!fifo_full || rx_ready_i);

  // Receiver FSM: bit timing, sampling and the one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (!sync2) state <= START;
        end
        START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= sync2 ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            shift   <= {sync2, shift[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) state <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (sync2) begin
              overrun_q <= fifo_full && !rx_ready_i;
              state     <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must not decode as endless 0x00 bytes.
          if (sync2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state != IDLE);
  assign rx_valid_o  = !fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (rx_ready_i),
    .wdata (shift),
    .rdata (rx_data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_o)
  );

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous 8N1 UART receiver, the receive-side counterpart of the core's uart_tx_o transmitter.
- Used in system benches and on the FPGA top to capture console output from the core.
- It can also feed a debug host path.
- Received bytes are buffered in a small FIFO and presented on a valid/ready stream.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200); must be >= 8.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_i  in  1  asynchronous serial input, idle high
- rx_data_o  out  8  byte at FIFO head
- rx_valid_o  out  1  FIFO non-empty
- rx_ready_i  in  1  consumer accepts head byte when rx_valid_o && rx_ready_i
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  one-cycle pulse: byte completed while FIFO full
- busy_o  out  1  FSM not in IDLE
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: rst_n is synchronous, active-low; clock clk.
  - rx_i passes through a 2-flop synchronizer whose flops reset to 1.
  - FSM resets to IDLE; bit counter, clk counter and shift register reset to 0.
  - FIFO empties.
  - Outputs after reset: rx_valid_o=0, rx_data_o=0, frame_err_o=0, overrun_o=0, busy_o=0, fifo_count_o=0.
- HALF = CLKS_PER_BIT/2 (integer division). The clk counter counts 0..N-1, then wraps to 0.
- IDLE:
  - Synchronized rx == 0 -> START with counter 0.
- START:
  - When counter == HALF-1, resample.
  - If 0 -> DATA (counter 0, bit index 0).
  - If 1 -> false start, back to IDLE with no pulse.
- DATA:
  - When counter == CLKS_PER_BIT-1, sample into shift register, LSB first.
  - After bit index 7 -> STOP.
- STOP: when counter == CLKS_PER_BIT-1, sample the stop bit.
  - Sample = 1, FIFO not full: push byte; -> IDLE.
  - Sample = 1, FIFO full: drop byte, overrun_o=1 for one cycle, FIFO unchanged; -> IDLE.
  - Sample = 0: drop byte, frame_err_o=1 for one cycle; -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until synchronized rx == 1, then -> IDLE.
  - This prevents a break condition from being decoded as repeated 0x00 bytes.
- Latency:
  - The pushed byte appears on rx_valid_o/rx_data_o after the same edge that samples the stop bit.
  - Total: 828 rising edges after the first edge that captures rx_i low, at default parameters.
- FIFO:
  - Show-ahead: rx_data_o is the head entry.
  - Push and pop in the same cycle are both performed; count is unchanged, including when the FIFO is full (pop frees the slot).
  - A push decision in the STOP cycle uses the pre-edge full flag. With full && pop in the same cycle, the push is accepted, not an overrun.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - rx_data_o holds the last head value when empty (no X).
- rx_ready_i while empty is ignored.
- busy_o = state != IDLE.
- Reset asserted mid-frame aborts the frame immediately. The partial byte is discarded and no pulses are generated.

Decomposition:
- uart_pkg holds:
  - FSM state enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Constant DATA_BITS=8.
  - Default CLKS_PER_BIT value.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): show-ahead FIFO with push/pop/full/empty/count. It is reusable by a future uart_tx buffer.
- FSM, counters and synchronizer stay in uart_rx.

Test Plan:
- Send byte 0x55 at 87 clk/bit, rx_ready_i=0:
  - rx_valid_o rises 828 edges after the start edge, rx_data_o=0x55, fifo_count_o=1.
  - Assert rx_ready_i one cycle -> rx_valid_o=0, fifo_count_o=0.
- Back-to-back bytes 0x00, 0xFF, 0xA5, 0x3C with no idle gap, ready held 1: consumer receives exactly those 4 bytes in order, no error pulses.
- Fill FIFO with 4 bytes (ready=0), send 0x77:
  - overrun_o pulses once, fifo_count_o stays 4, head still the first byte.
  - Repeat with ready=1 on the stop-sample cycle: 0x77 is accepted and no overrun occurs.
- Send 0x12 with stop bit forced 0, then hold rx_i low for 3 bit times, then high and send 0x34:
  - frame_err_o pulses once, no byte pushed during the low period.
  - Next output byte is 0x34.
- Glitch: rx_i low for 20 clk then high -> FSM returns to IDLE after the HALF check, busy_o drops, no byte and no pulse.
- Assert rst_n=0 for one cycle during bit 4 of byte 0x9C:
  - All outputs return to reset values, FIFO is empty.
  - The subsequent full frame 0x9C is received correctly.
